rgb_pwm_gen: RTL

RGB_PWM_GEN -- requirements
Module: rgb_pwm_gen

---
 rtl/rgb_pwm_pkg.sv | 18 +
 rtl/rgb_pwm_gen_channel.sv | 63 ++++++
 rtl/rgb_pwm_gen.sv | 114 +++++++++++
 3 files changed

// File: rtl/rgb_pwm_pkg.sv
// Shared constants for the RGB PWM generator: default duty width,
// channel indices and the update-state encoding.
package rgb_pwm_pkg;

    localparam int PWM_WIDTH_DEFAULT = 12;

    localparam int CH_R   = 0;
    localparam int CH_G   = 1;
    localparam int CH_B   = 2;
    localparam int NUM_CH = 3;

    // Single-slot update state (used when fading is disabled).
    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } upd_state_t;

endpackage

// File: rtl/rgb_pwm_gen_channel.sv
// One PWM channel: target (shadow) register, active duty, fade step and
// the registered comparator output.
// Build option RGB_PWM_FADE_EN: active steps by 1 toward target on each
// commit instead of jumping straight to it.
import rgb_pwm_pkg::*;

module pwm_channel #(
    parameter int PWM_WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PWM_WIDTH-1:0] pwm_ctr,
    input  logic                 load,
    input  logic [PWM_WIDTH-1:0] duty,
    input  logic                 commit,
`ifdef RGB_PWM_FADE_EN
    output logic                 differs,
`endif
    output logic                 pwm
);

    localparam logic [PWM_WIDTH-1:0] ONE = {{(PWM_WIDTH-1){1'b0}}, 1'b1};

    logic [PWM_WIDTH-1:0] target;
    logic [PWM_WIDTH-1:0] active;

    // Shadow register: captures the requested duty on each accepted transfer.
    always_ff @(posedge clk) begin
        if (rst)
            target <= '0;
        else if (load)
            target <= duty;
    end

    // Active duty only moves on a commit, which the top issues on period_tick.
    always_ff @(posedge clk) begin
        if (rst)
            active <= '0;
        else if (commit) begin
`ifdef RGB_PWM_FADE_EN
            if (active < target)
                active <= active + ONE;
            else if (active > target)
                active <= active - ONE;
`else
            active <= target;
`endif
        end
    end

    // Registered compare gives a glitch-free output one cycle behind the counter.
    always_ff @(posedge clk) begin
        if (rst)
            pwm <= 1'b0;
        else
            pwm <= (pwm_ctr < active);
    end

`ifdef RGB_PWM_FADE_EN
    assign differs = (active != target);
`endif

endmodule

// File: rtl/rgb_pwm_gen.sv
// RGB PWM generator: free-running period counter, duty-update handshake and
// three pwm_channel instances.
// Build option RGB_PWM_FADE_EN: always-ready input with per-period fading;
// without it a single-slot update is committed at the next period boundary.
//
// state      | meaning (fade disabled)
// -----------+------------------------------------------------------
// ST_IDLE    | no update queued, in_ready = 1
// ST_PENDING | target loaded, waiting for period_tick to commit it
import rgb_pwm_pkg::*;

module rgb_pwm_gen #(
    parameter int PWM_WIDTH = PWM_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PWM_WIDTH-1:0] in_r,
    input  logic [PWM_WIDTH-1:0] in_g,
    input  logic [PWM_WIDTH-1:0] in_b,
    output logic                 pwm_r,
    output logic                 pwm_g,
    output logic                 pwm_b,
    output logic                 period_tick,
    output logic                 busy
);

    localparam logic [PWM_WIDTH-1:0] CTR_MAX = '1;
    localparam logic [PWM_WIDTH-1:0] ONE     = {{(PWM_WIDTH-1){1'b0}}, 1'b1};

    logic [PWM_WIDTH-1:0] pwm_ctr;
    logic [PWM_WIDTH-1:0] duty_in [NUM_CH];
    logic [NUM_CH-1:0]    pwm_vec;
    logic                 xfer;
    logic                 commit;

    // Free-running period counter; wraps naturally at 2^PWM_WIDTH.
    always_ff @(posedge clk) begin
        if (rst)
            pwm_ctr <= '0;
        else
            pwm_ctr <= pwm_ctr + ONE;
    end

    assign period_tick = !rst && (pwm_ctr == CTR_MAX);
    assign xfer        = in_valid && in_ready;

`ifdef RGB_PWM_FADE_EN
    logic [NUM_CH-1:0] differs;

    assign in_ready = !rst;
    assign busy     = !rst && (|differs);
    assign commit   = period_tick;
`else
    upd_state_t state, next_state;

    // Update-state register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    // Next-state and handshake decode for the single-slot update.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = !rst;
                if (xfer)
                    next_state = ST_PENDING;
            end
            ST_PENDING: begin
                busy   = !rst;
                commit = period_tick;
                if (period_tick)
                    next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end
`endif

    assign duty_in[CH_R] = in_r;
    assign duty_in[CH_G] = in_g;
    assign duty_in[CH_B] = in_b;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .pwm_ctr (pwm_ctr),
            .load    (xfer),
            .duty    (duty_in[i]),
            .commit  (commit),
`ifdef RGB_PWM_FADE_EN
            .differs (differs[i]),
`endif
            .pwm     (pwm_vec[i])
        );
    end

    assign pwm_r = pwm_vec[CH_R];
    assign pwm_g = pwm_vec[CH_G];
    assign pwm_b = pwm_vec[CH_B];

endmodule
